keccak_pad_unit: RTL
====================

# keccak_pad_unit

Upstream message formatter for the Keccak core controller. Accepts a 64-bit message word stream with a last-word byte count. Applies FIPS 202 domain-separation and pad10*1 padding for the selected mode. Emits rate-aligned 64-bit block words through the `src_ready`/`src_read` handshake the controller consumes.

## Interface
- `W`, 64: data word width; fixed at 64 (one Keccak lane).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `mode`  in  2  00 SHA3-256 (R=17 words), 01 SHA3-512 (R=9), 10 SHAKE128 (R=21), 11 SHAKE256 (R=17). Sampled on the first accepted word of a message.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  input word accepted when `in_valid & in_ready`.
- `in_data`  in  64  message word; byte i occupies bits [8i+7:8i].
- `in_last`  in  1  final word of the message.
- `in_bytes`  in  4  valid bytes in the last word, 0..8. Ignored (treated as 8) when `in_last`=0. Values >8 are treated as 8.
- `src_ready`  out  1  output word available (registered).
- `src_read`  in  1  controller consumes the output word when `src_ready` is high.
- `dout`  out  64  padded block word (registered).
- `dout_last`  out  1  high with the final word of the padded message.
- `busy`  out  1  high from the first accepted word until the final word is consumed.

## Operation
- Suffix byte S: 0x06 for SHA3 modes, 0x1F for SHAKE modes. Final pad bit: 0x80 ORed into byte 7 of the last word of the last block.
- Word counter `wcnt` (5 bits) holds the block position of the next emitted word. It wraps R-1 → 0 and clears at message start.
- Output register is a single entry. It can load when it is empty or when `src_read` is consumed in the same cycle.
- States:
  - IDLE: `in_ready`=1. First accepted word latches mode/R, sets `busy`, and is processed as in PASS.
  - PASS: `in_ready` = load-able. Accepted word with `in_last`=0 → emitted unchanged, `wcnt`++.
  - Last word, k=`in_bytes`<8: emit bytes 0..k-1 = data, byte k = S, remaining bytes = 0.
    - If `wcnt`=R-1, OR 0x80 into byte 7, assert `dout_last`, go DONE.
    - Otherwise go ZERO.
  - Last word, k=8: emit unchanged and go SUFFIX.
  - SUFFIX: `in_ready`=0. Emit word = S in byte 0, rest zero.
    - If `wcnt`=R-1, also OR in 0x80 and assert `dout_last`, go DONE.
    - Otherwise go ZERO.
  - ZERO: `in_ready`=0. Emit zero words while `wcnt`<R-1. At `wcnt`=R-1, emit 0x8000_0000_0000_0000 with `dout_last`, go DONE.
  - DONE: `in_ready`=0. When the final word is consumed, clear `busy` and return to IDLE.
- k=7 at `wcnt`=R-1 places S and 0x80 in the same byte: 0x86 for SHA3, 0x9F for SHAKE.
- Empty message: `in_last`=1, `in_bytes`=0 → word 0 = S, then ZERO.
- `mode` changes while `busy` have no effect.

## Timing
- Reset values: `src_ready`=0, `dout`=0, `dout_last`=0, `busy`=0, state IDLE, `wcnt`=0. `in_ready` goes to 1 in the first cycle after `rst` deasserts.
- Latency: input accept at edge n → `src_ready`=1 with that word after edge n. Throughput is 1 word/cycle when `src_read` is held high.
- Generated words (SUFFIX/ZERO) issue one per cycle while consumed. With no back-pressure there are no bubbles between the last data word and padding.
- `src_read` while `src_ready`=0 is ignored. Without `src_read`, `dout`/`dout_last` stay stable, and `in_ready`=0 while the register is full.
- Consume and load in the same cycle: the register is replaced, and `src_ready` stays 1.
- Reset mid-message: the message is discarded, all state returns to reset values, and no partial block is emitted afterwards.

## Test plan
- SHA3-256, empty message (`in_last`=1, `in_bytes`=0):
  - 17 words out.
  - word0 = 0x0000_0000_0000_0006, words1-15 = 0.
  - word16 = 0x8000_0000_0000_0000 with `dout_last`; `busy` falls after it is consumed.
- SHA3-512, 9 full words, last with `in_bytes`=8:
  - 9 pass-through words (no `dout_last`).
  - Then 0x06, seven zero words, and 0x8000_0000_0000_0000 with `dout_last`: 18 words total.
- SHAKE128, 21 words, last `in_data`=0x0011_2233_4455_6677, `in_bytes`=7:
  - word20 = 0x9F11_2233_4455_6677 with `dout_last`.
  - No further words; `in_ready` returns to 1 in IDLE.
- SHAKE256, 3 bytes 0xABCDEF in a single last word: word0 = 0x0000_0000_1FAB_CDEF, 15 zeros, then 0x8000… as the last word.
- Back-pressure: hold `src_read`=0 for 5 cycles mid-stream.
  - `dout` stays stable and `in_ready`=0 while full.
  - After release, the sequence is unchanged and no words are lost or duplicated.
- Assert `rst`=0 during ZERO in a SHA3-256 message:
  - Outputs reach reset values immediately.
  - A following empty SHA3-256 message produces exactly the 17-word result above.

Source files
------------

// File: rtl/keccak_pad_unit.sv
// rtl/keccak_pad_unit.sv - FIPS 202 domain-separation and pad10*1 formatter for 64-bit message words
// Turns a byte-counted message word stream into rate-aligned block words for the Keccak controller.

module keccak_pad_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  input  logic        in_last,
  input  logic [3:0]  in_bytes,
  output logic        src_ready,
  input  logic        src_read,
  output logic [63:0] dout,
  output logic        dout_last,
  output logic        busy
);

  localparam int W = 64;
  localparam logic [W-1:0] PAD_END = 64'h8000_0000_0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_SUFFIX,
    S_ZERO,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [4:0]     wcnt_q;
  logic [4:0]     rlast_q;
  logic [7:0]     sfx_q;
  logic           src_ready_q;
  logic [W-1:0]   dout_q;
  logic           dout_last_q;
  logic           busy_q;

  logic           consume;
  logic           can_load;
  logic           accept;
  logic           idle;
  logic [4:0]     msg_rlast;
  logic [7:0]     msg_sfx;
  logic [4:0]     msg_cnt;
  logic [4:0]     next_cnt;
  logic           at_end;
  logic [3:0]     kbytes;
  logic [W-1:0]   last_word;

  // Last word index of a block (R-1) for each mode.
  function automatic logic [4:0] rlast_of(input logic [1:0] m);
    case (m)
      2'b00:   rlast_of = 5'd16;
      2'b01:   rlast_of = 5'd8;
      2'b10:   rlast_of = 5'd20;
      default: rlast_of = 5'd16;
    endcase
  endfunction

  function automatic logic [7:0] sfx_of(input logic [1:0] m);
    sfx_of = m[1] ? 8'h1F : 8'h06;
  endfunction

  assign consume  = src_ready_q & src_read;
  assign can_load = ~src_ready_q | src_read;
  assign idle     = (state_q == S_IDLE);
  assign in_ready = (idle || state_q == S_PASS) && can_load;
  assign accept   = in_valid & in_ready;

  // The first word of a message uses the live mode and a cleared counter.
  assign msg_rlast = idle ? rlast_of(mode) : rlast_q;
  assign msg_sfx   = idle ? sfx_of(mode)   : sfx_q;
  assign msg_cnt   = idle ? 5'd0           : wcnt_q;
  assign at_end    = (msg_cnt == msg_rlast);
  assign next_cnt  = at_end ? 5'd0 : msg_cnt + 5'd1;
  assign kbytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;

  always_comb begin
    last_word = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < kbytes) begin
        last_word[8*i +: 8] = in_data[8*i +: 8];
      end else if (4'(i) == kbytes) begin
        last_word[8*i +: 8] = msg_sfx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wcnt_q      <= '0;
      rlast_q     <= '0;
      sfx_q       <= '0;
      src_ready_q <= 1'b0;
      dout_q      <= '0;
      dout_last_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      if (consume) begin
        src_ready_q <= 1'b0;
      end
      case (state_q)
        S_IDLE, S_PASS: begin
          if (accept) begin
            busy_q      <= 1'b1;
            rlast_q     <= msg_rlast;
            sfx_q       <= msg_sfx;
            src_ready_q <= 1'b1;
            dout_last_q <= 1'b0;
            if (!in_last) begin
              dout_q  <= in_data;
              wcnt_q  <= next_cnt;
              state_q <= S_PASS;
            end else if (kbytes == 4'd8) begin
              dout_q  <= in_data;
              wcnt_q  <= next_cnt;
              state_q <= S_SUFFIX;
            end else if (at_end) begin
              dout_q      <= last_word | PAD_END;
              dout_last_q <= 1'b1;
              wcnt_q      <= msg_cnt;
              state_q     <= S_DONE;
            end else begin
              dout_q  <= last_word;
              wcnt_q  <= next_cnt;
              state_q <= S_ZERO;
            end
          end
        end
        S_SUFFIX: begin
          if (can_load) begin
            src_ready_q <= 1'b1;
            if (wcnt_q == rlast_q) begin
              dout_q      <= {56'd0, sfx_q} | PAD_END;
              dout_last_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              dout_q  <= {56'd0, sfx_q};
              wcnt_q  <= wcnt_q + 5'd1;
              state_q <= S_ZERO;
            end
          end
        end
        S_ZERO: begin
          if (can_load) begin
            src_ready_q <= 1'b1;
            if (wcnt_q == rlast_q) begin
              dout_q      <= PAD_END;
              dout_last_q <= 1'b1;
              state_q     <= S_DONE;
            end else begin
              dout_q <= '0;
              wcnt_q <= wcnt_q + 5'd1;
            end
          end
        end
        S_DONE: begin
          if (consume) begin
            busy_q      <= 1'b0;
            dout_last_q <= 1'b0;
            wcnt_q      <= '0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign src_ready = src_ready_q;
  assign dout      = dout_q;
  assign dout_last = dout_last_q;
  assign busy      = busy_q;

endmodule
